// File: rtl/anc_fir_mac64.sv
// anc_fir_mac64: sequential one-tap-per-clock FIR multiply-accumulate.
// A sample enters the tap delay line, TAPS products are summed into a
// guard-banded accumulator, and the clamped 64-bit result is offered on a
// valid/ready output. The clamp is symmetric so a downstream negation of
// out_sum can never overflow.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a sample; in_ready high; coefficient writes OK
// MAC   | one tap per clock: acc += x[idx]*c[idx]; writes are dropped
// OUT   | result held on out_sum/out_sat until out_ready; writes OK
module anc_fir_mac64 #(
    parameter int TAPS = 16,
    parameter int DW   = 32,
    parameter int CW   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DW-1:0]      in_sample,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]      coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [63:0]        out_sum,
    output logic                      out_sat,
    output logic                      busy
);

    localparam int AW   = $clog2(TAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = 64 + AW;

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic signed [ACCW-1:0] SAT_HI = {{(AW + 1){1'b0}}, {63{1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic signed [63:0]      out_sum_q, out_sum_d;
    logic                    out_sat_q, out_sat_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    accept;

    logic signed [DW-1:0]    x_q [TAPS];
    logic signed [CW-1:0]    c_q [TAPS];

    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [63:0]      clamp_val;
    logic                    clamp_hit;
    logic                    addr_ok;
    logic                    coef_wr;

    // Address range guard only matters when TAPS is not a power of two.
    if ((1 << AW) == TAPS) begin : g_addr_pow2
        assign addr_ok = 1'b1;
    end else begin : g_addr_npow2
        assign addr_ok = (int'(coef_addr) < TAPS);
    end

    // A write arriving while the MAC loop reads c[] is dropped, not queued.
    assign coef_wr = coef_we && addr_ok && (state_q != MAC);

    // Current tap product, accumulated sum and its symmetric clamp.
    always_comb begin
        prod      = x_q[idx_q] * c_q[idx_q];
        acc_sum   = acc_q + {{(ACCW - PW){prod[PW-1]}}, prod};
        clamp_hit = 1'b0;
        clamp_val = acc_sum[63:0];
        if (acc_sum > SAT_HI) begin
            clamp_val = SAT_HI[63:0];
            clamp_hit = 1'b1;
        end else if (acc_sum < SAT_LO) begin
            clamp_val = SAT_LO[63:0];
            clamp_hit = 1'b1;
        end
    end

    // Next-state and next-register logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept     = 1'b1;
                    acc_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    out_sum_d   = clamp_val;
                    out_sat_d   = clamp_hit;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Sequencer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Tap delay line: shift by one on each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                x_q[k] <= x_q[k-1];
            end
            x_q[0] <= in_sample;
        end
    end

    // Coefficient bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                c_q[k] <= '0;
            end
        end else if (coef_wr) begin
            c_q[coef_addr] <= coef_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q == MAC);

endmodule

// File: tb/tb_anc_fir_mac64.sv
// Directed bench for anc_fir_mac64 with hand-computed expected sums.
module tb_anc_fir_mac64;

    localparam int TAPS = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_sample;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [31:0] coef_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [63:0] out_sum;
    logic               out_sat;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    anc_fir_mac64 #(.TAPS(TAPS), .DW(32), .CW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [31:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(posedge clk); #1;
        coef_we   = 1'b0;
    endtask

    // Offers one sample (optionally with a same-edge coefficient write),
    // waits for the result and accepts it with a single-cycle out_ready.
    task automatic run_txn(input string tag, input logic [31:0] s,
                           input bit we, input logic [3:0] wa, input logic [31:0] wd,
                           output logic [63:0] sum, output logic sat);
        int lat;
        in_valid  = 1'b1;
        in_sample = s;
        coef_we   = we;
        coef_addr = wa;
        coef_data = wd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        check_eq({tag, ".busy"}, 64'(busy), 64'd1);
        check_eq({tag, ".in_ready_mac"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'(TAPS));
        sum = out_sum;
        sat = out_sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".out_sum"}, out_sum, 64'd0);
        check_eq({tag, ".out_sat"}, 64'(out_sat), 64'd0);
        check_eq({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] sum;
        logic        sat;
        int          seen;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;

        // Reset held with random inputs
        repeat (4) begin
            in_valid  = 1'($urandom);
            in_sample = $urandom;
            coef_we   = 1'($urandom);
            coef_addr = 4'($urandom);
            coef_data = $urandom;
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            check_reset_outputs("rst_hold");
        end
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("rst_idle");

        // Impulse response: c[k]=k+1, then 1 followed by zeros
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), 32'(k + 1));
        for (int k = 0; k < TAPS; k++) begin
            run_txn($sformatf("imp%0d", k), (k == 0) ? 32'd1 : 32'd0, 1'b0, 4'd0, 32'd0, sum, sat);
            check_eq($sformatf("imp%0d.sum", k), sum, 64'(k + 1));
            check_eq($sformatf("imp%0d.sat", k), 64'(sat), 64'd0);
        end

        // Sign handling: only c[0] = -3, sample 5
        write_coef(4'd0, 32'hFFFF_FFFD);
        for (int k = 1; k < TAPS; k++) write_coef(4'(k), 32'd0);
        run_txn("sign", 32'd5, 1'b0, 4'd0, 32'd0, sum, sat);
        check_eq("sign.sum", sum, 64'hFFFF_FFFF_FFFF_FFF1);
        check_eq("sign.sat", 64'(sat), 64'd0);

        // Positive saturation: all c = -2^31, samples -2^31.
        // First pass still has x[1]=5: 2^62 - 5*2^31, unclamped.
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), 32'h8000_0000);
        for (int k = 0; k < TAPS; k++) begin
            run_txn($sformatf("satp%0d", k), 32'h8000_0000, 1'b0, 4'd0, 32'd0, sum, sat);
            if (k == 0) begin
                check_eq("satp_first.sum", sum, 64'h3FFF_FFFD_8000_0000);
                check_eq("satp_first.sat", 64'(sat), 64'd0);
            end
        end
        check_eq("satp.sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
        check_eq("satp.sat", 64'(sat), 64'd1);

        // Negative saturation: all c = 2^31-1, samples -2^31
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), 32'h7FFF_FFFF);
        for (int k = 0; k < TAPS; k++)
            run_txn($sformatf("satn%0d", k), 32'h8000_0000, 1'b0, 4'd0, 32'd0, sum, sat);
        check_eq("satn.sum", sum, 64'h8000_0000_0000_0001);
        check_eq("satn.sat", 64'(sat), 64'd1);

        // Exactly -2^63 must still clamp: four products of -2^61
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), (k < 4) ? 32'h4000_0000 : 32'd0);
        run_txn("min63", 32'h8000_0000, 1'b0, 4'd0, 32'd0, sum, sat);
        check_eq("min63.sum", sum, 64'h8000_0000_0000_0001);
        check_eq("min63.sat", 64'(sat), 64'd1);

        // Backpressure: c[0]=7, sample 3 -> 21, held 7 cycles in OUT
        write_coef(4'd0, 32'd7);
        for (int k = 1; k < 4; k++) write_coef(4'(k), 32'd0);
        in_valid  = 1'b1;
        in_sample = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 64) begin
            @(posedge clk); #1;
            seen++;
        end
        check_eq("bp.latency", 64'(seen), 64'(TAPS));
        for (int i = 0; i < 7; i++) begin
            in_valid  = i[0];
            in_sample = 32'd100;
            coef_we   = ~i[0];
            coef_addr = 4'd1;
            coef_data = 32'd9;
            @(posedge clk); #1;
            check_eq($sformatf("bp%0d.sum", i), out_sum, 64'd21);
            check_eq($sformatf("bp%0d.valid", i), 64'(out_valid), 64'd1);
            check_eq($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp.in_ready_back", 64'(in_ready), 64'd1);
        // x[1] must be 3 (nothing captured in OUT), c[1] must be 9 (write landed)
        run_txn("bp_after", 32'd0, 1'b0, 4'd0, 32'd0, sum, sat);
        check_eq("bp_after.sum", sum, 64'd27);

        // Reset in the middle of MAC at idx=5
        in_valid  = 1'b1;
        in_sample = 32'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rmac.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rmac_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (TAPS + 4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("rmac.no_output", 64'(seen), 64'd0);
        check_reset_outputs("rmac_idle");
        // c[1]=5 exposes a stale x[1]; c[0]=2 written on the same edge as sample 4
        write_coef(4'd1, 32'd5);
        run_txn("rmac_next", 32'd4, 1'b1, 4'd0, 32'd2, sum, sat);
        check_eq("rmac_next.sum", sum, 64'd8);
        check_eq("rmac_next.sat", 64'(sat), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
